mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the `decoupled` request/response memory protocol used by the fetch stage and other initiators. It accepts requests on `mem_req`, performs the access against an internal word array, and returns exactly one in-order response per request on `mem_resp` after a fixed minimum latency. It is the simulation and FPGA backing store placed behind the memory arbiter, with a bounded number of outstanding requests and full backpressure support on the response side.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; must be a power of two.
- `LATENCY`, 1: minimum number of cycles from request acceptance to response valid; legal range 1..15.
- `MAX_OUTSTANDING`, 4: maximum number of accepted requests whose responses have not yet been drained; legal range 1..16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_req`  decoupled.in  data = {`a` 32, `we` 1, `be` 4, `d` 32}  request channel.
- `mem_resp`  decoupled.out  data 32  response channel, carrying the read word.

## Operation
- A request is accepted when `mem_req.valid && mem_req.ready`.
- Word index is `a[2 +: $clog2(DEPTH_WORDS)]`. `a[1:0]` and the upper address bits are ignored, so out-of-range addresses alias.
- Read data is sampled from the array in the acceptance cycle.
- If `we`=1, bytes with `be[i]`=1 are written from `d[8i+7:8i]` at the end of the acceptance cycle. The write's response carries the pre-write word.
- A request accepted after a write observes that write.
- `we`, `be` and `d` may be X on reads and must not affect state.
- Accepted entries enter an in-order queue of `MAX_OUTSTANDING` entries. Each entry holds its read data and a countdown timer.
- `mem_resp.valid` is 1 when the queue is non-empty and the head's countdown has expired.
- The head is popped when `mem_resp.valid && mem_resp.ready`.
- `mem_req.ready` = (occupancy < `MAX_OUTSTANDING`). It is registered-state-derived only, with no combinational path from `mem_resp.ready`. A full queue blocks acceptance even in a cycle where the head drains.
- Occupancy counter: +1 on accept, −1 on drain, unchanged on simultaneous accept and drain. It must never exceed `MAX_OUTSTANDING` or underflow.
- Countdown timers decrement every cycle, including while the head is backpressured, and saturate at 0.
- No flush input. Initiators that flush (for example, fetch) must still consume every outstanding response.

## Timing
- A request accepted in cycle t makes its response valid at the earliest in cycle t+`LATENCY`. It appears later only if older responses are still queued or stalled.
- With `mem_resp.ready` held at 1 and `LATENCY`=1, a request is accepted every cycle and throughput is 1 per cycle.
- Once asserted, `mem_resp.valid` and `mem_resp.data` stay stable until the response is drained.
- Reset, including mid-operation: the queue empties and occupancy returns to 0. `mem_resp.valid`=0 and `mem_req.ready`=1 from the first cycle after reset (subject to the stall feature). Array contents are not reset and are preserved across reset.
- While `rst`=1, no request is accepted and no write is performed.

## Configuration
- `MEM_RESPONDER_STALL_EN`: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle.
  - When LFSR bit 0 is 1, `mem_req.ready` is forced to 0 for that cycle, injecting pseudo-random request backpressure.
  - Response timing is unaffected apart from requests arriving later.
- When `MEM_RESPONDER_STALL_EN` is undefined, the LFSR is absent and `mem_req.ready` depends only on occupancy.

## Test plan
- Write then read: write `a`=0x10, `d`=0xDEADBEEF, `be`=4'hF, then read 0x10. The read response is 0xDEADBEEF and the write's response is the prior word.
- Byte enables: starting from 0x11223344 at 0x20, write `d`=0xAABBCCDD with `be`=4'b0101. A subsequent read returns 0x11BB33DD.
- Latency: `LATENCY`=3, a single read accepted in cycle 10, `mem_resp.ready`=1. `mem_resp.valid` first rises in cycle 13 and drops in cycle 14.
- Full and backpressure: `MAX_OUTSTANDING`=4, `mem_resp.ready`=0, 6 reads presented back-to-back. Exactly 4 are accepted, then `mem_req.ready`=0. Data holds stable.
  - Releasing `mem_resp.ready` returns the responses in order.
  - `mem_req.ready` reasserts the cycle after the first drain.
- Reset mid-operation: with 3 responses queued, pulse `rst` for 1 cycle. Afterwards `mem_resp.valid`=0, `mem_req.ready`=1, and no stale response appears. A previously written word still reads back unchanged.
- Stall (`MEM_RESPONDER_STALL_EN`): run 1000 random reads and writes against a reference model. All data matches and the response count equals the accept count.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - in-order word-array memory responder with fixed minimum latency
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_req_valid/ready request handshake
//   mem_req_a           byte address; word index is a[2 +: log2(DEPTH_WORDS)], the rest aliases
//   mem_req_we          write enable
//   mem_req_be          byte enables, bit i covers d[8i+7:8i]
//   mem_req_d           write data
//   mem_resp_valid/ready response handshake
//   mem_resp_data       word read in the acceptance cycle (pre-write value for writes)
//
// Optional feature macro: MEM_RESPONDER_STALL_EN
//   Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that forces
//   mem_req_ready low on cycles where its bit 0 is set.

module mem_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [31:0] mem_req_a,
    input  logic        mem_req_we,
    input  logic [3:0]  mem_req_be,
    input  logic [31:0] mem_req_d,
    output logic        mem_resp_valid,
    input  logic        mem_resp_ready,
    output logic [31:0] mem_resp_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // A timer loaded with LATENCY-1 reads zero exactly LATENCY cycles after acceptance.
    localparam logic [3:0]       TIMER_INIT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);

    logic [31:0]      mem_array [DEPTH_WORDS];

    logic [31:0]      q_data  [MAX_OUTSTANDING];
    logic [3:0]       q_timer [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] idx;
    logic             not_full;
    logic             accept;
    logic             drain;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_a[31:2+IDX_W], mem_req_a[1:0]};

    assign idx      = mem_req_a[2 +: IDX_W];
    assign not_full = (count < CNT_MAX);

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign mem_req_ready = not_full && !rst && !lfsr[0];
`else
    // Ready never looks at mem_resp_ready: a full queue stays closed even in a
    // cycle where the head drains. It is held low while rst is asserted so that
    // no handshake can appear to complete during reset.
    assign mem_req_ready = not_full && !rst;
`endif

    assign accept = mem_req_valid && mem_req_ready;

    // The head timer saturates at zero and the head only moves on a drain,
    // so valid and data hold steady while backpressured.
    assign mem_resp_valid = (count != '0) && (q_timer[head] == 4'd0);
    assign mem_resp_data  = q_data[head];
    assign drain          = mem_resp_valid && mem_resp_ready;

    // Response queue: circular buffer; every timer counts down every cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_timer[i] != 4'd0) begin
                q_timer[i] <= q_timer[i] - 4'd1;
            end
        end

        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                // Combinational array read gives the pre-write word for writes.
                q_data[tail]  <= mem_array[idx];
                q_timer[tail] <= TIMER_INIT;
                tail          <= (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);
            end

            if (drain) begin
                head <= (head == PTR_LAST) ? '0 : head + PTR_W'(1);
            end

            case ({accept, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Word array: not reset, so contents survive rst. accept is already
    // false during reset, which blocks writes then.
    always_ff @(posedge clk) begin
        if (accept && mem_req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_req_be[b]) begin
                    mem_array[idx][8*b +: 8] <= mem_req_d[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a queue/array model
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_d = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;

    mem_responder #(
        .DEPTH_WORDS    (DEPTH),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (req_valid),
        .mem_req_ready (req_ready),
        .mem_req_a     (req_a),
        .mem_req_we    (req_we),
        .mem_req_be    (req_be),
        .mem_req_d     (req_d),
        .mem_resp_valid(resp_valid),
        .mem_resp_ready(resp_ready),
        .mem_resp_data (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          dut_acc = 0;
    int          dut_resp = 0;
    logic [31:0] mem_m [int];
    resp_t       pend [$];
    logic [31:0] got [$];
    logic        obs_valid;
    logic        obs_ready;
    logic        last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, update the model, then
    // advance to just after the rising edge where the caller drives new inputs.
    task automatic step();
        logic        exp_valid;
        logic        exp_ready;
        int          idx;
        logic [31:0] w;
        resp_t       r;
        @(negedge clk);
        exp_valid = (pend.size() > 0) && (cyc >= pend[0].due);
        exp_ready = !rst && (pend.size() < MAXO);
        obs_valid = resp_valid;
        obs_ready = req_ready;
        if (!rst) begin
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_valid) check("resp_data", resp_data, pend[0].data);
            if (resp_valid && resp_ready) dut_resp++;
            if (req_valid && req_ready) dut_acc++;
        end
        last_acc = req_valid && exp_ready;
        if (exp_valid && resp_ready && !rst) begin
            got.push_back(resp_data);
            void'(pend.pop_front());
        end
        if (last_acc) begin
            idx = int'((req_a >> 2) & 32'(DEPTH - 1));
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            r.data = w;
            r.due = cyc + LAT;
            pend.push_back(r);
            if (req_we) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) w[8*b +: 8] = req_d[8*b +: 8];
                mem_m[idx] = w;
            end
        end
        if (rst) pend.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
        req_a = a; req_we = we; req_be = be; req_d = d; req_valid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 50 && !last_acc; i++) step();
        check("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain_all();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && pend.size() > 0; i++) step();
        step();
        check("drain_idle", 32'(obs_valid), 32'd0);
    endtask

    initial begin
        int          n;
        int          acc_cnt;
        int          stale;
        int          acc0;
        int          resp0;
        logic [31:0] prior;
        logic [4:0]  lat_v;

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_valid", 32'(obs_valid), 32'd0);
        check("reset_ready", 32'(obs_ready), 32'd1);

        // Initialise words 0..15 with random data
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(32'(i * 4), 1'b1, 4'hF, $urandom);
        drain_all();

        // Write then read at 0x10
        prior = mem_m[4];
        send(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        send(32'h10, 1'b0, 4'h0, 32'h0);
        drain_all();
        n = got.size();
        check("wr_prev_word", got[n-2], prior);
        check("wr_rd_data", got[n-1], 32'hDEADBEEF);

        // Byte enables at 0x20
        send(32'h20, 1'b1, 4'hF, 32'h11223344);
        send(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        drain_all();
        n = got.size();
        check("be_prev", got[n-2], 32'h11223344);
        check("be_merge", got[n-1], 32'h11BB33DD);

        // Latency: accepted in cycle t, valid in t+3 only
        send(32'h24, 1'b0, 4'h0, 32'h0);
        req_valid = 1'b0;
        lat_v = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            lat_v[k] = obs_valid;
        end
        check("lat_t2", 32'(lat_v[2]), 32'd0);
        check("lat_t3", 32'(lat_v[3]), 32'd1);
        check("lat_t4", 32'(lat_v[4]), 32'd0);

        // Full and backpressure: 6 reads back-to-back, responses blocked
        resp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            req_a = 32'(i * 4); req_we = 1'b0; req_be = 4'h0; req_d = '0; req_valid = 1'b1;
            step();
            if (last_acc) acc_cnt++;
        end
        check("full_accepts", 32'(acc_cnt), 32'd4);
        check("full_ready_low", 32'(obs_ready), 32'd0);
        repeat (4) step();
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_data", resp_data, mem_m[0]);
        n = got.size();
        resp_ready = 1'b1;
        step();
        check("ready_at_drain", 32'(obs_ready), 32'd0);
        step();
        check("ready_after_drain", 32'(obs_ready), 32'd1);
        drain_all();
        for (int k = 0; k < 4; k++) check("order", got[n+k], mem_m[k]);

        // Reset mid-operation with 3 responses queued
        resp_ready = 1'b0;
        send(32'h10, 1'b0, 4'h0, 32'h0);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        send(32'h24, 1'b0, 4'h0, 32'h0);
        req_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_ready", 32'(obs_ready), 32'd1);
        resp_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            step();
            stale += int'(obs_valid);
        end
        check("no_stale", 32'(stale), 32'd0);
        send(32'h10, 1'b0, 4'h0, 32'h0);
        drain_all();
        check("rst_mem_kept", got[got.size()-1], 32'hDEADBEEF);

        // Randomised traffic with aliasing upper/lower address bits
        acc0 = dut_acc;
        resp0 = dut_resp;
        for (int i = 0; i < 600; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_be     = 4'($urandom);
            req_d      = $urandom;
            req_a      = (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_FC03);
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain_all();
        check("rand_count", 32'(dut_resp - resp0), 32'(dut_acc - acc0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
